branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch predictor for the pipelined RISC-V core. It merges direction prediction (saturating counters) and a tagged target buffer into one block, selectable between bimodal and gshare indexing. It sits beside the PC. Lookups are issued with the next-fetch PC, and resolved branches and jumps are written back from the ID stage. It also keeps saturating performance counters.

## Interface
- PC_W, 64: PC width.
- ENTRIES, 64: table entries; power of two ≥ 4. IDX_W = log2(ENTRIES).
- CNT_W, 2: direction counter width (≥ 1).
- TAG_W, 8: tag width; requires IDX_W+2+TAG_W ≤ PC_W.
- GHR_W, 6: global history length; requires GHR_W ≤ IDX_W.
- MODE, 0: 0 = bimodal, 1 = gshare.
- PERF_W, 32: performance counter width.

Ports:
- clk  in  1  core clock.
- arst  in  1  reset. One clock; reset is asynchronous and active-high.
- en  in  1  global enable. When low, no state changes and outputs hold.
- flush  in  1  invalidate all entries and clear the GHR.
- lookup_pc  in  PC_W  next-fetch PC.
- pred_taken  out  1  predicted taken.
- pred_target  out  PC_W  predicted target.
- pred_ghr  out  GHR_W  GHR snapshot used for this lookup; carried down the pipe.
- upd_valid  in  1  update strobe.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_ghr  in  GHR_W  snapshot that was returned with its prediction.
- upd_is_branch  in  1  conditional branch.
- upd_is_jump  in  1  unconditional jump.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual target.
- upd_pred_taken  in  1  direction that was predicted.
- perf_branches  out  PERF_W  count of resolved conditional branches.
- perf_mispredicts  out  PERF_W  count of direction mispredicts.

## Operation
**Entry contents:** valid, tag, target, is_jump, cnt[CNT_W-1:0].

**Index and tag**
- Bimodal index = pc[IDX_W+1:2].
- Gshare index = pc[IDX_W+1:2] XOR zero-extended GHR.
- Lookups use the live GHR. Updates use upd_ghr.
- tag = pc[IDX_W+TAG_W+1:IDX_W+2].

**Lookup**
- hit = valid && tag match.
- pred_taken = hit && (is_jump || cnt MSB).
- pred_target = hit ? target : 0.
- pred_ghr = GHR (forced to 0 in MODE 0).

**Update** (applies when en && upd_valid && (upd_is_branch || upd_is_jump))
- On a miss with taken or jump: allocate the entry. Set valid=1, tag, target, is_jump, and cnt = 2^(CNT_W-1) if taken, else 2^(CNT_W-1)-1.
- On a miss with a not-taken branch: no allocation.
- On a hit:
  - cnt increments (saturating at all-ones) if taken, decrements (saturating at 0) if not.
  - target is overwritten only when taken.
  - is_jump is refreshed.
- Conflicting tags replace the existing entry.

**GHR**
- On a conditional-branch update with MODE=1: GHR <= {GHR[GHR_W-2:0], upd_taken}.
- In MODE 0 the GHR is constant 0.

**Perf counters**
- perf_branches increments on each conditional-branch update.
- perf_mispredicts increments when upd_pred_taken != upd_taken.
- Both saturate at all-ones. Neither is affected by flush.

**Flush**
- Clears all valid bits and the GHR in one cycle.
- Flush takes priority over a same-cycle update; that update is dropped, including its perf increment.

**Reset:** every entry is cleared, GHR = 0, all outputs = 0, and both perf counters = 0.

## Timing
- Lookup latency is 1 cycle. lookup_pc sampled at edge N drives pred_* after edge N, which aligns with current_pc.
- An update sampled at edge N affects lookups sampled at edge N+1 or later.
- A same-edge lookup of the same entry returns the pre-update state (read-before-write).
- Flush sampled at edge N: lookups at N+1 miss. The lookup at N returns the old state.
- en low: tables, GHR, perf counters and outputs all hold. Updates presented while en is low are lost.
- arst asserted mid-operation clears everything immediately, independent of clk. Operation resumes on the first edge after deassertion.

## Structure
- Package bp_pkg holds:
  - constants BP_BIMODAL=0 and BP_GSHARE=1;
  - the entry struct (valid, tag, target, is_jump, cnt);
  - functions for the counter init value and the index/tag computation.
- Sub-module bp_sat_counter: parametrised up/down saturating counter (width, init, inc, dec). Used for the direction counters and both perf counters.
- Tables are implemented as flops (asynchronous clear required), not SRAM macros.

## Test plan
All scenarios use ENTRIES=64 and TAG_W=8. Scenarios 1-4 and 6 use MODE=0.
- Reset, then lookup 0x100 -> pred_taken=0, pred_target=0, pred_ghr=0, both perf counters 0.
- Update 0x100, branch taken, target 0x80; lookup 0x100 on the next cycle -> pred_taken=1, target 0x80 (cnt=2). Then a not-taken update -> pred_taken=0, target still 0x80.
- Four taken updates of 0x100 -> cnt=3. One not-taken update -> cnt=2, pred_taken remains 1. Six not-taken updates -> cnt=0, no underflow.
- 0x100 trained; lookup 0x4100 (same index 0, tag 0x41 vs 0x01) -> miss. Jump update at 0x4100 with target 0x200 -> 0x4100 hits with target 0x200, and 0x100 now misses.
- MODE=1, GHR_W=6: taken-branch update -> pred_ghr=6'b000001. A subsequent update of pc 0x104 with upd_ghr=1 trains index 0, and lookup 0x104 then hits.
- Same-cycle update and lookup of 0x100 -> old result returned.
- Flush -> all lookups miss.
- Three branch updates with one mispredict -> perf_branches=3, perf_mispredicts=1. Flush together with an update -> the update is dropped and perf is unchanged.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch predictor shared types and helpers.
// Index/tag math is width-generic over a 64-bit PC view.
package bp_pkg;

  localparam int BP_BIMODAL   = 0;
  localparam int BP_GSHARE    = 1;
  localparam int BP_MAX_W     = 64;
  localparam int BP_MAX_CNT_W = 16;

  typedef struct packed {
    logic                    valid;
    logic [BP_MAX_W-1:0]     tag;
    logic [BP_MAX_W-1:0]     target;
    logic                    is_jump;
    logic [BP_MAX_CNT_W-1:0] cnt;
  } bp_entry_t;

  function automatic logic [15:0] bp_cnt_init(
    input int   w,
    input logic taken
  );
    logic [15:0] h;
    h = 16'd1 << (w - 1);
    return taken ? h : h - 16'd1;
  endfunction

  function automatic logic bp_cnt_msb(
    input logic [15:0] cnt,
    input int          w
  );
    return |(cnt & (16'd1 << (w - 1)));
  endfunction

  function automatic logic [31:0] bp_index(
    input logic [63:0] pc,
    input logic [31:0] ghr,
    input int          idx_w
  );
    logic [63:0] v;
    v = ((pc >> 2) ^ 64'(ghr)) & ((64'd1 << idx_w) - 64'd1);
    return 32'(v);
  endfunction

  function automatic logic [63:0] bp_tag(
    input logic [63:0] pc,
    input int          idx_w,
    input int          tag_w
  );
    return (pc >> (idx_w + 2)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Up/down saturating counter with synchronous load.
// Used for direction counters and perf counters.
module bp_sat_counter #(
  parameter int           W    = 2,
  parameter logic [W-1:0] INIT = '0
) (
  input  logic         clk_i,
  input  logic         arst_i,
  input  logic         ld_i,
  input  logic [W-1:0] ld_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins; otherwise step and clamp at the rails
  always_comb begin
    cnt_d = cnt_q;
    if (ld_i)
      cnt_d = ld_val_i;
    else if (inc_i && !dec_i && cnt_q != '1)
      cnt_d = cnt_q + 1'b1;
    else if (dec_i && !inc_i && cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  // counter state
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) cnt_q <= INIT;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Bimodal/gshare direction predictor with tagged target buffer.
// Registered lookup, read-before-write against ID-stage updates.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PC_W    = 64,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int TAG_W   = 8,
  parameter int GHR_W   = 6,
  parameter int MODE    = 0,
  parameter int PERF_W  = 32
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              en,
  input  logic              flush,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_target,
  output logic [GHR_W-1:0]  pred_ghr,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [GHR_W-1:0]  upd_ghr,
  input  logic              upd_is_branch,
  input  logic              upd_is_jump,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  input  logic              upd_pred_taken,
  output logic [PERF_W-1:0] perf_branches,
  output logic [PERF_W-1:0] perf_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [ENTRIES-1:0] v_q;
  logic [ENTRIES-1:0] jmp_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [PC_W-1:0]    tgt_q [ENTRIES];
  logic [CNT_W-1:0]   cnt   [ENTRIES];

  logic [GHR_W-1:0] ghr_q, ghr_d;
  logic [GHR_W-1:0] l_ghr, u_ghr;
  logic [IDX_W-1:0] l_idx, u_idx;
  logic [TAG_W-1:0] l_tag, u_tag;
  logic [CNT_W-1:0] init_val;

  logic             pred_taken_q;
  logic [PC_W-1:0]  pred_target_q;
  logic [GHR_W-1:0] pred_ghr_q;

  bp_entry_t l_ent;
  logic      l_hit, l_taken, u_hit;
  logic      upd_go, alloc, train;
  logic      br_inc, mis_inc;

  assign l_ghr = (MODE == BP_GSHARE) ? ghr_q   : '0;
  assign u_ghr = (MODE == BP_GSHARE) ? upd_ghr : '0;

  assign l_idx = IDX_W'(bp_index(64'(lookup_pc), 32'(l_ghr), IDX_W));
  assign u_idx = IDX_W'(bp_index(64'(upd_pc), 32'(u_ghr), IDX_W));
  assign l_tag = TAG_W'(bp_tag(64'(lookup_pc), IDX_W, TAG_W));
  assign u_tag = TAG_W'(bp_tag(64'(upd_pc), IDX_W, TAG_W));

  // gather the looked-up entry into one view
  always_comb begin
    l_ent         = '0;
    l_ent.valid   = v_q[l_idx];
    l_ent.tag     = 64'(tag_q[l_idx]);
    l_ent.target  = 64'(tgt_q[l_idx]);
    l_ent.is_jump = jmp_q[l_idx];
    l_ent.cnt     = 16'(cnt[l_idx]);
  end

  assign l_hit   = l_ent.valid && (l_ent.tag == 64'(l_tag));
  assign l_taken = l_hit &&
                   (l_ent.is_jump || bp_cnt_msb(l_ent.cnt, CNT_W));

  assign u_hit  = v_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign upd_go = en && !flush && upd_valid &&
                  (upd_is_branch || upd_is_jump);
  assign alloc  = upd_go && !u_hit && (upd_taken || upd_is_jump);
  assign train  = upd_go && u_hit;

  assign init_val = CNT_W'(bp_cnt_init(CNT_W, upd_taken));

  assign br_inc  = upd_go && upd_is_branch;
  assign mis_inc = upd_go && (upd_pred_taken != upd_taken);

  // per-entry direction counters
  for (genvar e = 0; e < ENTRIES; e++) begin : g_cnt
    logic sel;
    assign sel = (u_idx == IDX_W'(e));
    bp_sat_counter #(.W(CNT_W)) u_cnt (
      .clk_i    (clk),
      .arst_i   (arst),
      .ld_i     (alloc && sel),
      .ld_val_i (init_val),
      .inc_i    (train && sel && upd_taken),
      .dec_i    (train && sel && !upd_taken),
      .cnt_o    (cnt[e])
    );
  end

  bp_sat_counter #(.W(PERF_W)) u_perf_br (
    .clk_i    (clk),
    .arst_i   (arst),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (br_inc),
    .dec_i    (1'b0),
    .cnt_o    (perf_branches)
  );

  bp_sat_counter #(.W(PERF_W)) u_perf_mis (
    .clk_i    (clk),
    .arst_i   (arst),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .inc_i    (mis_inc),
    .dec_i    (1'b0),
    .cnt_o    (perf_mispredicts)
  );

  // history shifts on applied conditional branches only
  always_comb begin
    ghr_d = ghr_q;
    if (flush)
      ghr_d = '0;
    else if (br_inc && MODE == BP_GSHARE)
      ghr_d = GHR_W'({ghr_q, upd_taken});
  end

  // history register
  always_ff @(posedge clk or posedge arst) begin
    if (arst)    ghr_q <= '0;
    else if (en) ghr_q <= ghr_d;
  end

  // valid/tag/target/jump tables; flush beats update
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v_q   <= '0;
      jmp_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
      end
    end else if (en) begin
      if (flush) begin
        v_q <= '0;
      end else if (alloc) begin
        v_q[u_idx]   <= 1'b1;
        tag_q[u_idx] <= u_tag;
        tgt_q[u_idx] <= upd_target;
        jmp_q[u_idx] <= upd_is_jump;
      end else if (train) begin
        if (upd_taken)
          tgt_q[u_idx] <= upd_target;
        jmp_q[u_idx] <= upd_is_jump;
      end
    end
  end

  // registered prediction from pre-update table state
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
      pred_ghr_q    <= '0;
    end else if (en) begin
      pred_taken_q  <= l_taken;
      pred_target_q <= l_hit ? PC_W'(l_ent.target) : '0;
      pred_ghr_q    <= l_ghr;
    end
  end

  assign pred_taken  = pred_taken_q;
  assign pred_target = pred_target_q;
  assign pred_ghr    = pred_ghr_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor.
// Bimodal instance carries most checks; gshare instance covers history.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        arst, en, flush;
  logic [63:0] lookup_pc, upd_pc, upd_target;
  logic [5:0]  upd_ghr;
  logic        upd_valid, upd_is_branch, upd_is_jump;
  logic        upd_taken, upd_pred_taken;

  logic        t0, t1;
  logic [63:0] tg0, tg1;
  logic [5:0]  g0, g1;
  logic [31:0] pb0, pm0, pb1, pm1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  branch_predictor #(.MODE(0)) dut0 (
    .clk(clk), .arst(arst), .en(en), .flush(flush),
    .lookup_pc(lookup_pc),
    .pred_taken(t0), .pred_target(tg0), .pred_ghr(g0),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .perf_branches(pb0), .perf_mispredicts(pm0)
  );

  branch_predictor #(.MODE(1)) dut1 (
    .clk(clk), .arst(arst), .en(en), .flush(flush),
    .lookup_pc(lookup_pc),
    .pred_taken(t1), .pred_target(tg1), .pred_ghr(g1),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_is_branch(upd_is_branch), .upd_is_jump(upd_is_jump),
    .upd_taken(upd_taken), .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .perf_branches(pb1), .perf_mispredicts(pm1)
  );

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [63:0] pc);
    lookup_pc = pc;
    tick();
  endtask

  task automatic upd(input logic [63:0] pc, input logic br, jmp, tk,
                     input logic [63:0] tgt, input logic ptk,
                     input logic [5:0] g);
    upd_valid      = 1'b1;
    upd_pc         = pc;
    upd_is_branch  = br;
    upd_is_jump    = jmp;
    upd_taken      = tk;
    upd_target     = tgt;
    upd_pred_taken = ptk;
    upd_ghr        = g;
    tick();
    upd_valid      = 1'b0;
  endtask

  initial begin
    arst = 1'b1; en = 1'b1; flush = 1'b0;
    lookup_pc = '0; upd_pc = '0; upd_target = '0; upd_ghr = '0;
    upd_valid = 1'b0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
    upd_taken = 1'b0; upd_pred_taken = 1'b0;
    #12 arst = 1'b0;
    tick();

    // reset state
    look(64'h100);
    check("rst_taken", t0, 0);
    check("rst_target", tg0, 0);
    check("rst_ghr0", g0, 0);
    check("rst_ghr1", g1, 0);
    check("rst_pb", pb0, 0);
    check("rst_pm", pm0, 0);

    // gshare history
    upd(64'h100, 1, 0, 1, 64'h80, 0, 6'd0);
    look(64'h100);
    check("gs_ghr", g1, 6'b000001);
    check("gs_miss", t1, 0);
    check("bm_ghr", g0, 0);
    upd(64'h104, 0, 1, 1, 64'h300, 0, 6'd1);
    look(64'h104);
    check("gs_hit", t1, 1);
    check("gs_tgt", tg1, 64'h300);

    // async reset, no clock edge
    #3 arst = 1'b1;
    #1;
    check("ar_taken", t1, 0);
    check("ar_tgt", tg1, 0);
    check("ar_ghr", g1, 0);
    check("ar_pb", pb0, 0);
    #2 arst = 1'b0;
    tick();

    // allocate, then not-taken keeps target
    upd(64'h100, 1, 0, 1, 64'h80, 0, 0);
    look(64'h100);
    check("al_taken", t0, 1);
    check("al_tgt", tg0, 64'h80);
    upd(64'h100, 1, 0, 0, 64'h999, 1, 0);
    look(64'h100);
    check("nt_taken", t0, 0);
    check("nt_tgt", tg0, 64'h80);

    // saturation at top: cnt 1 -> 3, then 2
    for (int i = 0; i < 4; i++)
      upd(64'h100, 1, 0, 1, 64'h80, 1, 0);
    upd(64'h100, 1, 0, 0, 64'h80, 1, 0);
    look(64'h100);
    check("sat_hi", t0, 1);

    // saturation at zero: every step predicts not-taken
    for (int i = 0; i < 6; i++) begin
      upd(64'h100, 1, 0, 0, 64'h80, 1, 0);
      look(64'h100);
      check($sformatf("sat_lo%0d", i), t0, 0);
    end

    // tag conflict replaces entry
    look(64'h4100);
    check("cf_miss", t0, 0);
    check("cf_miss_tgt", tg0, 0);
    upd(64'h4100, 0, 1, 1, 64'h200, 0, 0);
    look(64'h4100);
    check("cf_hit", t0, 1);
    check("cf_tgt", tg0, 64'h200);
    look(64'h100);
    check("cf_old", t0, 0);
    check("cf_old_tgt", tg0, 0);

    // same-edge update and lookup sees old state
    lookup_pc = 64'h100;
    upd(64'h100, 1, 0, 1, 64'h180, 0, 0);
    check("rbw_taken", t0, 0);
    check("rbw_tgt", tg0, 0);
    look(64'h100);
    check("rbw_new", t0, 1);
    check("rbw_newtgt", tg0, 64'h180);

    // enable low: hold and drop update
    en = 1'b0;
    lookup_pc = 64'h4100;
    upd(64'h100, 1, 0, 0, 64'h0, 1, 0);
    check("en_hold", t0, 1);
    check("en_hold_tgt", tg0, 64'h180);
    en = 1'b1;
    look(64'h100);
    check("en_lost", t0, 1);

    // flush: same-edge lookup is old, next misses
    lookup_pc = 64'h100;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("fl_old", t0, 1);
    check("fl_old_tgt", tg0, 64'h180);
    look(64'h100);
    check("fl_miss", t0, 0);
    check("fl_miss_tgt", tg0, 0);

    // perf counters from a clean reset
    arst = 1'b1;
    #2 arst = 1'b0;
    tick();
    upd(64'h100, 1, 0, 1, 64'h80, 1, 0);
    upd(64'h104, 1, 0, 0, 64'h84, 0, 0);
    upd(64'h108, 1, 0, 1, 64'h88, 0, 0);
    check("pf_br", pb0, 3);
    check("pf_mis", pm0, 1);
    flush = 1'b1;
    upd(64'h10c, 1, 0, 1, 64'h8c, 0, 0);
    flush = 1'b0;
    check("pf_fl_br", pb0, 3);
    check("pf_fl_mis", pm0, 1);
    look(64'h10c);
    check("pf_fl_drop", t0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
